// File: rtl/frame_aligner_param.sv
// rtl/frame_aligner_param.sv - parametrised two-header byte-stream frame aligner
//
// Hunts for either of two 2-byte header patterns in a one-byte-per-clock
// stream. It confirms lock after LOCK_CNT on-period headers. It flywheels
// through up to UNLOCK_CNT-1 consecutive missed headers. While locked it
// delivers aligned payload bytes.
//
// Ports:
//   clk               rising-edge clock
//   reset_n           asynchronous active-low reset
//   rx_data           received byte, valid every cycle
//   fr_byte_position  predicted frame index of the byte on rx_data
//   frame_detect      lock indication
//   hdr_type          type of the last matched header (0: HDR1, 1: HDR2)
//   pay_valid         pay_data holds an aligned payload byte
//   pay_data          payload byte (holds its value when pay_valid is low)
//   pay_first         payload byte 0 marker
//   pay_last          payload byte PAYLOAD_LEN-1 marker
//   lock_lost         one-cycle pulse when lock drops
//   hdr_err_cnt       saturating count of missed headers while locked
module frame_aligner_param #(
  parameter int                DATA_W      = 8,
  parameter int                PAYLOAD_LEN = 10,
  parameter int                LOCK_CNT    = 3,
  parameter int                UNLOCK_CNT  = 4,
  parameter logic [DATA_W-1:0] HDR1_LSB    = 8'hAA,
  parameter logic [DATA_W-1:0] HDR1_MSB    = 8'hAF,
  parameter logic [DATA_W-1:0] HDR2_LSB    = 8'h55,
  parameter logic [DATA_W-1:0] HDR2_MSB    = 8'hBA,
  // Derived from PAYLOAD_LEN; do not override.
  parameter int                POS_W       = $clog2(PAYLOAD_LEN + 2)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  output logic [POS_W-1:0]  fr_byte_position,
  output logic              frame_detect,
  output logic              hdr_type,
  output logic              pay_valid,
  output logic [DATA_W-1:0] pay_data,
  output logic              pay_first,
  output logic              pay_last,
  output logic              lock_lost,
  output logic [7:0]        hdr_err_cnt
);

  localparam int FRAME_LEN = PAYLOAD_LEN + 2;
  localparam int GW        = $clog2(LOCK_CNT + 1);
  localparam int MW        = $clog2(UNLOCK_CNT + 1);

  localparam logic [POS_W-1:0] LAST_POS    = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0] CHECK_POS   = POS_W'(1);
  localparam logic [POS_W-1:0] FIRST_PAY   = POS_W'(2);
  // Counter values that become LOCK_CNT / UNLOCK_CNT after this cycle's increment.
  localparam logic [GW-1:0]    LOCK_LAST   = GW'(LOCK_CNT - 1);
  localparam logic [MW-1:0]    UNLOCK_LAST = MW'(UNLOCK_CNT - 1);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] prev_q;
  logic              prev_valid_q;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [GW-1:0]     good_q, good_d;
  logic [MW-1:0]     miss_q, miss_d;
  logic              fd_q, fd_d;
  logic              ht_q, ht_d;
  logic              lost_q, lost_d;
  logic [7:0]        err_q, err_d;
  logic              pv_q, pv_d;
  logic [DATA_W-1:0] pd_q, pd_d;
  logic              pf_q, pf_d;
  logic              pl_q, pl_d;

  logic m1, m2, match, match_type, check, in_pay;

  always_comb begin
    // Header 1 wins if both patterns could match at once.
    m1         = prev_valid_q && (prev_q == HDR1_LSB) && (rx_data == HDR1_MSB);
    m2         = prev_valid_q && (prev_q == HDR2_LSB) && (rx_data == HDR2_MSB);
    match      = m1 || m2;
    match_type = !m1;
    check      = (pos_q == CHECK_POS);

    state_d = state_q;
    pos_d   = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
    good_d  = good_q;
    miss_d  = miss_q;
    fd_d    = fd_q;
    ht_d    = ht_q;
    lost_d  = 1'b0;
    err_d   = err_q;

    // Payload is driven off the pre-update state, so bytes keep flowing
    // through missed headers until lock actually drops.
    in_pay = (state_q == LOCKED) && (pos_q >= FIRST_PAY);
    pv_d   = in_pay;
    pd_d   = in_pay ? rx_data : pd_q;
    pf_d   = in_pay && (pos_q == FIRST_PAY);
    pl_d   = in_pay && (pos_q == LAST_POS);

    unique case (state_q)
      HUNT: begin
        pos_d = '0;
        if (match) begin
          pos_d  = FIRST_PAY;
          good_d = GW'(1);
          ht_d   = match_type;
          if (LOCK_CNT == 1) begin
            state_d = LOCKED;
            fd_d    = 1'b1;
          end else begin
            state_d = CONFIRM;
          end
        end
      end
      CONFIRM: begin
        if (check) begin
          if (match) begin
            good_d = good_q + GW'(1);
            ht_d   = match_type;
            if (good_q == LOCK_LAST) begin
              state_d = LOCKED;
              fd_d    = 1'b1;
            end
          end else begin
            state_d = HUNT;
            pos_d   = '0;
            good_d  = '0;
          end
        end
      end
      LOCKED: begin
        if (check) begin
          if (match) begin
            miss_d = '0;
            ht_d   = match_type;
          end else begin
            miss_d = miss_q + MW'(1);
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (miss_q == UNLOCK_LAST) begin
              state_d = HUNT;
              fd_d    = 1'b0;
              lost_d  = 1'b1;
              pos_d   = '0;
              miss_d  = '0;
            end
          end
        end
      end
      default: begin
        state_d = HUNT;
        pos_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      pos_q        <= '0;
      good_q       <= '0;
      miss_q       <= '0;
      fd_q         <= 1'b0;
      ht_q         <= 1'b0;
      lost_q       <= 1'b0;
      err_q        <= '0;
      pv_q         <= 1'b0;
      pd_q         <= '0;
      pf_q         <= 1'b0;
      pl_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= rx_data;
      prev_valid_q <= 1'b1;
      pos_q        <= pos_d;
      good_q       <= good_d;
      miss_q       <= miss_d;
      fd_q         <= fd_d;
      ht_q         <= ht_d;
      lost_q       <= lost_d;
      err_q        <= err_d;
      pv_q         <= pv_d;
      pd_q         <= pd_d;
      pf_q         <= pf_d;
      pl_q         <= pl_d;
    end
  end

  assign fr_byte_position = pos_q;
  assign frame_detect     = fd_q;
  assign hdr_type         = ht_q;
  assign pay_valid        = pv_q;
  assign pay_data         = pd_q;
  assign pay_first        = pf_q;
  assign pay_last         = pl_q;
  assign lock_lost        = lost_q;
  assign hdr_err_cnt      = err_q;

endmodule

// File: doc/frame_aligner_param.md
# frame_aligner_param

Parametrised byte-stream frame aligner, the next generation of the two-header (AA/AF, 55/BA) aligner. It hunts for either of two 2-byte header patterns in a one-byte-per-clock receive stream and confirms lock after LOCK_CNT consecutive headers at the frame period. It then flywheels through up to UNLOCK_CNT-1 consecutive missing headers before dropping lock. Unlike the previous block, it also delivers aligned payload bytes with first/last markers, reports which header type was seen, and counts header errors. It sits directly behind the byte deserialiser and feeds the frame parser.

## Interface
- DATA_W, 8, width of rx_data and pay_data.
- PAYLOAD_LEN, 10, payload bytes per frame. FRAME_LEN = PAYLOAD_LEN+2. Legal range ≥1.
- LOCK_CNT, 3, consecutive on-period headers needed to assert frame_detect. Legal range ≥1.
- UNLOCK_CNT, 4, consecutive on-period header misses needed to drop frame_detect. Legal range ≥1.
- HDR1_LSB / HDR1_MSB, 8'hAA / 8'hAF, header type 0, in arrival order.
- HDR2_LSB / HDR2_MSB, 8'h55 / 8'hBA, header type 1.
- POS_W, $clog2(FRAME_LEN), derived; not for override.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  DATA_W  received byte, valid every cycle.
- fr_byte_position  out  POS_W  predicted frame index of the byte currently on rx_data.
- frame_detect  out  1  lock indication.
- hdr_type  out  1  type of the last matched header.
- pay_valid  out  1  pay_data holds an aligned payload byte.
- pay_data  out  DATA_W  payload byte.
- pay_first  out  1  qualifies pay_valid: payload byte 0.
- pay_last  out  1  qualifies pay_valid: payload byte PAYLOAD_LEN-1.
- lock_lost  out  1  one-cycle pulse when lock drops.
- hdr_err_cnt  out  8  saturating count of missed headers while LOCKED.

## Operation
- prev_data is a register holding the last rx_data. prev_valid is cleared by reset and set on the first post-reset edge.
- match = prev_valid && ((prev_data==HDR1_LSB && rx_data==HDR1_MSB) || (prev_data==HDR2_LSB && rx_data==HDR2_MSB)). If both types match, HDR1 wins.
- FSM states: HUNT, CONFIRM, LOCKED. Reset state is HUNT.
- HUNT:
  - fr_byte_position is held at 0.
  - On match at any cycle: fr_byte_position<=2, good_cnt<=1, hdr_type latched.
  - Next state is LOCKED if LOCK_CNT==1 (and frame_detect<=1), else CONFIRM.
- Outside HUNT: fr_byte_position increments every cycle and wraps FRAME_LEN-1 -> 0.
- Header check happens only on cycles with fr_byte_position==1. Matches at other positions are ignored in CONFIRM and LOCKED.
- CONFIRM, at a check cycle:
  - Match: good_cnt+1 and hdr_type latched. If good_cnt+1==LOCK_CNT, go to LOCKED and set frame_detect<=1.
  - Miss: go to HUNT, fr_byte_position<=0, good_cnt<=0.
- LOCKED, at a check cycle:
  - Match: miss_cnt<=0 and hdr_type latched.
  - Miss: miss_cnt+1 and hdr_err_cnt+1, saturating at 255. If miss_cnt+1==UNLOCK_CNT, go to HUNT with frame_detect<=0, lock_lost<=1 for one cycle, fr_byte_position<=0, miss_cnt<=0.
- Payload output: while state is LOCKED and fr_byte_position is in 2..FRAME_LEN-1, on the next cycle set pay_valid<=1 and pay_data<=rx_data.
  - pay_first is set when the position was 2.
  - pay_last is set when the position was FRAME_LEN-1.
  - Otherwise pay_valid, pay_first and pay_last are 0. pay_data holds its last value.
  - Payload keeps flowing through missed headers until lock actually drops.
- Headers of mixed types in consecutive frames count as valid.

## Timing
- Reset values: every output is 0, state is HUNT, and all counters are 0. Assertion of reset_n low mid-frame clears everything asynchronously. On release, the first cycle cannot produce a match because prev_valid==0.
- Latency rules:
  - frame_detect rises in the cycle after the MSB of the LOCK_CNT-th header is on rx_data.
  - frame_detect falls in the cycle after the UNLOCK_CNT-th missed check cycle.
  - pay_* outputs appear 1 cycle after the corresponding rx_data byte.
  - lock_lost is coincident with the cycle in which frame_detect falls.
- The LSB of a header may equal the MSB of the previous byte pair; overlapping detection is allowed, e.g. AA AA AF matches on AF.
- Lock and unlock both evaluate only at check cycles. A false header mid-payload never disturbs lock.
- hdr_err_cnt is never cleared except by reset.

## Test plan
- Defaults; header1 at cycles 0/1, 12/13, 24/25 with random payload -> fr_byte_position==2 at cycle 2; frame_detect 0 through cycle 25 and 1 at cycle 26; first pay_valid with pay_first at cycle 27.
- Same as above, then rx_data held at 8'h00 from cycle 36 -> misses at cycles 37, 49, 61 and 73; hdr_err_cnt==4; frame_detect 0 and lock_lost 1 at cycle 74 only; pay_valid pulses continue until then.
- Header1 at cycles 0/1 and header2 at cycles 12/13 and 24/25 -> lock at cycle 26, hdr_type==1.
- Locked stream with AA AF injected at payload positions 5/6 -> no change in fr_byte_position, frame_detect or hdr_err_cnt.
- Header1 at cycles 0/1 and garbage at cycles 12/13 -> return to HUNT with fr_byte_position==0 at cycle 14; a new header at cycles 20/21 gives fr_byte_position==2 at cycle 22.
- reset_n low for 1 cycle while LOCKED mid-payload -> all outputs 0 immediately; the lock sequence then restarts from HUNT.
